// File: rtl/seq_alu_if.sv
// Issue/result handshake bundle for seq_alu: operands and op select in,
// registered result and flags out, each side with valid/ready.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       sel;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             Cout;
    logic             Negative;
    logic             Zero;
    logic             Overflow;

    modport master (
        output in_valid, A, B, sel, Cin, out_ready,
        input  in_ready, out_valid, Y, Cout, Negative, Zero, Overflow
    );

    modport slave (
        input  in_valid, A, B, sel, Cin, out_ready,
        output in_ready, out_valid, Y, Cout, Negative, Zero, Overflow
    );
endinterface

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus a WIDTH-cycle
// shift-add unsigned multiplier; result and flags held until drained.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOTA = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_SUBB = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_SHL  = 4'b1010;
    localparam logic [3:0] OP_ASL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_SAR  = 4'b1101;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     sum_add, sum_sub, sum_subb;
    logic [WIDTH-1:0]   op_y;
    logic               op_c, op_v;
    logic               is_mul;

    assign is_mul       = (bus.sel == OP_MUL);
    assign bus.in_ready = (state == IDLE);
    assign bus.out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = is_mul ? MUL : DONE;
            MUL:     if (cnt == LAST) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sum_add  = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
    assign sum_sub  = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
    assign sum_subb = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, bus.Cin};

    // Single-cycle result, evaluated on the live inputs and captured at accept.
    always_comb begin
        op_y = '0;
        op_c = 1'b0;
        op_v = 1'b0;
        case (bus.sel)
            OP_AND:  op_y = bus.A & bus.B;
            OP_OR:   op_y = bus.A | bus.B;
            OP_NOTA: op_y = ~bus.A;
            OP_NOR:  op_y = ~(bus.A | bus.B);
            OP_XOR:  op_y = bus.A ^ bus.B;
            OP_NAND: op_y = ~(bus.A & bus.B);
            OP_ADD: begin
                {op_c, op_y} = sum_add;
                op_v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (op_y[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                {op_c, op_y} = sum_sub;
                op_v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (op_y[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUBB: begin
                {op_c, op_y} = sum_subb;
                op_v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (op_y[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SHL, OP_ASL: begin
                op_y = {bus.A[WIDTH-2:0], 1'b0};
                op_c = bus.A[WIDTH-1];
                op_v = bus.A[WIDTH-1] ^ bus.A[WIDTH-2];
            end
            OP_SHR: begin
                op_y = {1'b0, bus.A[WIDTH-1:1]};
                op_c = bus.A[0];
            end
            OP_SAR: begin
                op_y = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]};
                op_c = bus.A[0];
            end
            default: ;
        endcase
    end

    // Shift-add step: conditional add into the upper half, then shift the
    // whole accumulator right with the carry entering at the top.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    assign acc_nxt = {mul_sum, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            cnt          <= '0;
            bus.Y        <= '0;
            bus.Cout     <= 1'b0;
            bus.Negative <= 1'b0;
            bus.Zero     <= 1'b0;
            bus.Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    if (is_mul) begin
                        mcand  <= bus.A;
                        mplier <= bus.B;
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        bus.Y        <= op_y;
                        bus.Cout     <= op_c;
                        bus.Negative <= op_y[WIDTH-1];
                        bus.Zero     <= (op_y == '0);
                        bus.Overflow <= op_v;
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bus.Y        <= acc_nxt[WIDTH-1:0];
                        bus.Cout     <= 1'b0;
                        bus.Negative <= acc_nxt[WIDTH-1];
                        bus.Zero     <= (acc_nxt[WIDTH-1:0] == '0);
                        bus.Overflow <= |acc_nxt[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed checks of seq_alu: reset, arith flags, multiply latency/result,
// backpressure hold, shifts and reset during a multiply.
module tb_seq_alu;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_alu_if #(.WIDTH(32)) bus ();
    seq_alu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {out_valid, Y, Cout, Negative, Zero, Overflow}
    function automatic logic [36:0] obs();
        return {bus.out_valid, bus.Y, bus.Cout, bus.Negative, bus.Zero, bus.Overflow};
    endfunction

    task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b, input logic c);
        bus.in_valid = 1'b1;
        bus.sel = s;
        bus.A = a;
        bus.B = b;
        bus.Cin = c;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.sel = '0;
        bus.Cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs() !== 37'h0) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", obs(), 37'h0);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
        end
    endtask

    task automatic test_add();
        logic [36:0] e;
        issue(4'b0110, 32'h7FFF_FFFF, 32'h1, 1'b0);
        e = {1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL add_ovf got %h exp %h", obs(), e); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL add_busy got %b exp 0", bus.in_ready); end
        drain();
        issue(4'b0110, 32'hFFFF_FFFF, 32'h0, 1'b1);
        e = {1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL add_carry got %h exp %h", obs(), e); end
        drain();
    endtask

    task automatic test_sub();
        logic [36:0] e;
        issue(4'b0111, 32'd5, 32'd5, 1'b0);
        e = {1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL sub_zero got %h exp %h", obs(), e); end
        drain();
        issue(4'b1000, 32'd3, 32'd5, 1'b1);
        e = {1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL subb_borrow got %h exp %h", obs(), e); end
        drain();
        issue(4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        e = {1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL reserved got %h exp %h", obs(), e); end
        drain();
    endtask

    task automatic test_mul();
        logic [36:0] e;
        int lat;
        issue(4'b1001, 32'h0001_0000, 32'h0001_0001, 1'b0);
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid) break;
        end
        checks++;
        if (lat !== 32) begin errors++; $display("FAIL mul_latency got %0d exp 32", lat); end
        e = {1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL mul_ovf got %h exp %h", obs(), e); end
        drain();
        issue(4'b1001, 32'd1234, 32'd5678, 1'b0);
        bus.A = 32'hDEAD_BEEF;
        bus.B = 32'h1234_5678;
        bus.sel = 4'b0000;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            lat++;
            if (k == 3) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy got %b exp 0", bus.in_ready); end
            end
            if (bus.out_valid) break;
        end
        e = {1'b1, 32'd7006652, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL mul_small got %h exp %h lat %0d", obs(), e, lat); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [36:0] e;
        issue(4'b1101, 32'h8000_0001, 32'h0, 1'b0);
        e = {1'b1, 32'hC000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        // a competing request during the hold must be ignored
        bus.in_valid = 1'b1;
        bus.sel = 4'b0000;
        bus.A = 32'h0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs() !== e || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL sar_hold%0d got %h rdy %b exp %h rdy 0", k, obs(), bus.in_ready, e);
            end
            @(posedge clk); #1;
        end
        drain();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_ready got rdy %b vld %b exp rdy 1 vld 0", bus.in_ready, bus.out_valid);
        end
        issue(4'b1010, 32'h4000_0000, 32'h0, 1'b0);
        e = {1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL shl got %h exp %h", obs(), e); end
        drain();
    endtask

    task automatic test_reset_mid_mul();
        logic [36:0] e;
        int rose;
        issue(4'b1001, 32'd7, 32'd9, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs() !== 37'h0) begin errors++; $display("FAIL rst_mul got %h exp %h", obs(), 37'h0); end
        rst_n = 1'b1;
        rose = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) rose++;
        end
        checks++;
        if (rose !== 0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mul_quiet got vld_cycles %0d rdy %b exp 0 rdy 1", rose, bus.in_ready);
        end
        issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        e = {1'b1, 32'hF000_F000, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL and_after_rst got %h exp %h", obs(), e); end
        drain();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the combinational 32-bit ALU. It provides full-width logic ops, add/sub with carry-in, single-bit shifts and an iterative shift-add multiplier behind a valid/ready interface. Results and flags are registered. It sits between the operand/issue logic and the writeback stage. Simple ops complete in one cycle; multiply takes WIDTH cycles.

## Interface
- WIDTH, 32: operand/result width (≥4).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; asserted only in IDLE.
- A, B  in  WIDTH  operands.
- sel  in  4  op select.
- Cin  in  1  carry-in for ADD and SUBB.
- out_valid  out  1  result registers valid.
- out_ready  in  1  downstream accepts result.
- Y  out  WIDTH  result.
- Cout, Negative, Zero, Overflow  out  1 each  flags, registered with Y.

## Operation
- An op is accepted when in_valid && in_ready. A, B, sel and Cin are latched on accept; later input changes are ignored.
- Op encoding (all bitwise ops are full-width):
  - 0000 AND, 0001 OR, 0010 NOT A, 0011 NOR, 0100 XOR, 0101 NAND. For these, Cout=0 and Overflow=0.
  - 0110 ADD: {Cout,Y}=A+B+Cin. Overflow = (A[W-1]==B[W-1]) && (Y[W-1]!=A[W-1]).
  - 0111 SUB: {Cout,Y}=A+~B+1, so Cout=1 means no borrow. Overflow = (A[W-1]!=B[W-1]) && (Y[W-1]!=A[W-1]).
  - 1000 SUBB: {Cout,Y}=A+~B+Cin. Overflow is computed as for SUB.
  - 1001 MUL, unsigned: Y = low WIDTH bits of A*B. Overflow=1 iff the high WIDTH bits are nonzero. Cout=0.
  - 1010 SHL and 1011 ASL: Y={A[W-2:0],0}, Cout=A[W-1], Overflow=A[W-1]^A[W-2].
  - 1100 SHR: Y={0,A[W-1:1]}, Cout=A[0], Overflow=0.
  - 1101 SAR: Y={A[W-1],A[W-1:1]}, Cout=A[0], Overflow=0.
  - 1110, 1111 reserved: Y=0, Cout=0, Overflow=0.
- For all ops: Negative=Y[W-1] and Zero=(Y==0).
- FSM states and transitions:
  - IDLE: in_ready=1. Accept of a non-MUL op goes to DONE, with results registered at the same edge. Accept of MUL goes to MUL.
  - MUL: 2W-bit product accumulator cleared on accept, counter 0..WIDTH-1. Each cycle: if multiplier LSB is 1, add multiplicand into the upper half; then shift right one bit. After the WIDTH-th cycle, load Y and flags and go to DONE.
  - DONE: out_valid=1, and Y and flags are held stable. When out_ready=1, go to IDLE at that edge.
- in_ready=0 in MUL and DONE. No new op is accepted in the cycle a result is drained.
- rst_n=0 at any edge, including mid-MUL or in DONE with out_ready=0:
  - state goes to IDLE and any in-progress op is discarded;
  - out_valid=0, Y=0, Cout=0, Negative=0, Zero=0, Overflow=0, counter=0, accumulator=0;
  - in_ready=1 from the first cycle after reset releases.

## Timing
- Non-MUL op accepted at edge N: out_valid=1 after edge N, i.e. 1-cycle latency.
- MUL accepted at edge N: out_valid=1 after edge N+WIDTH.
- Result held indefinitely while out_ready=0. Drain edge D: out_valid=0 and in_ready=1 after D.
- Peak throughput: one simple op per 2 cycles; one MUL per WIDTH+2 cycles.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored and nothing is queued.
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.

## Test plan
- Reset/idle: hold rst_n=0 for 2 cycles, then release → out_valid=0, Y=0, all flags 0, in_ready=1.
- ADD, WIDTH=32: A=0x7FFFFFFF, B=1, Cin=0 → after 1 cycle Y=0x80000000, Negative=1, Overflow=1, Cout=0, Zero=0. Then A=0xFFFFFFFF, B=0, Cin=1 → Y=0, Cout=1, Zero=1, Overflow=0.
- SUB/SUBB: A=5, B=5 via SUB → Y=0, Zero=1, Cout=1. A=3, B=5 via SUBB with Cin=1 → Y=0xFFFFFFFE, Cout=0, Negative=1.
- MUL: A=0x10000, B=0x10001 → out_valid exactly 32 cycles after accept, Y=0x00010000, Overflow=1. A=1234, B=5678 → Y=7006652, Overflow=0. Changing A/B during MUL has no effect.
- Backpressure and shifts:
  - SAR A=0x80000001 with out_ready=0 for 5 cycles → Y=0xC0000000, Cout=1, Negative=1, held stable for all 5 cycles with in_ready=0.
  - Then assert out_ready → in_ready=1 the next cycle.
  - SHL A=0x40000000 → Y=0x80000000, Overflow=1, Cout=0.
- Reset mid-MUL: deassert rst_n 10 cycles into a MUL → out_valid never rises for that op, all outputs 0. A following AND with A=0xF0F0F0F0, B=0xFF00FF00 → Y=0xF000F000.
